fir_filter_mac: RTL and testbench

FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_sat.sv | 32 +++
 rtl/fir_filter_mac.sv | 124 ++++++++++++
 tb/tb_fir_filter_mac.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC filter: FSM state encoding and
// width derivations used by the top level and its sub-module.
package fir_pkg;

  typedef logic [1:0] fir_state_t;

  localparam fir_state_t ST_IDLE = 2'd0;
  localparam fir_state_t ST_MAC  = 2'd1;
  localparam fir_state_t ST_OUT  = 2'd2;

  // Number of bits needed to index n distinct values (n >= 1).
  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: full product plus growth for summing taps products.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + fir_clog2(taps);
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Arithmetic right shift followed by saturation to a signed OUT_W range.
module fir_sat
  import fir_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Work one bit wider than either side so the range compare never overflows.
  localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]  shifted;
  logic signed [EXT_W-1:0] ext;

  // Shift, sign-extend, then clamp to the representable output range.
  always_comb begin
    shifted = din >>> SHIFT;
    ext     = EXT_W'(shifted);
    if (ext > MAX_V)      dout = MAX_V[OUT_W-1:0];
    else if (ext < MIN_V) dout = MIN_V[OUT_W-1:0];
    else                  dout = ext[OUT_W-1:0];
  end

endmodule

// File: rtl/fir_filter_mac.sv
// Serial FIR filter: one multiplier, one product per cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// OUT, and y_out is held constant for as long as out_valid is high.
//
// Timeline for a sample transferred on edge 0: edges 1..TAPS accumulate the
// TAPS products, edge TAPS+1 registers the shifted/saturated result and
// enters OUT, so out_valid is seen after edge TAPS+1.
module fir_filter_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DATA_W-1:0]    x_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        coef_we,
  input  logic [fir_clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic signed [OUT_W-1:0]     y_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  dbg_state
);

  localparam int ADDR_W = fir_clog2(TAPS);
  localparam int CNT_W  = fir_clog2(TAPS + 1);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = fir_acc_w(DATA_W, COEF_W, TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS);

  fir_state_t                state;
  logic [CNT_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  taps  [TAPS];
  logic signed [COEF_W-1:0]  coefs [TAPS];
  logic signed [DATA_W-1:0]  tap_sel;
  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [OUT_W-1:0]   sat_y;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign dbg_state = state;

  // Select the tap/coefficient pair for the current accumulate step.
  always_comb begin
    tap_sel  = '0;
    coef_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == CNT_W'(k)) begin
        tap_sel  = taps[k];
        coef_sel = coefs[k];
      end
    end
  end

  assign prod     = PROD_W'(tap_sel) * PROD_W'(coef_sel);
  assign prod_ext = ACC_W'(prod);

  fir_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (acc),
    .dout (sat_y)
  );

  // Coefficient bank: writable only while idle, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coefs[k] <= '0;
      coefs[0] <= COEF_W'(1);
    end else if (state == ST_IDLE && coef_we && (32'(coef_addr) < TAPS)) begin
      coefs[coef_addr] <= coef_data;
    end
  end

  // Control FSM, delay line, accumulator and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      acc   <= '0;
      y_out <= '0;
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            taps[0] <= x_in;
            for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (idx != LAST_IDX) begin
            acc <= acc + prod_ext;
            idx <= idx + CNT_W'(1);
          end else begin
            y_out <= sat_y;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// Bench for fir_filter_mac: directed vectors plus randomized traffic,
// scored against an arithmetic FIR model with a queue-based scoreboard.
module tb_fir_filter_mac;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 0;
  localparam int ADDR_W = 2;
  localparam int CLK_P  = 10;
  localparam longint LAT = (TAPS + 1) * CLK_P + CLK_P / 2;
  localparam longint Y_MAX = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint Y_MIN = -(64'sd1 <<< (OUT_W - 1));

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [DATA_W-1:0] x_in;
  logic in_valid, in_ready;
  logic coef_we;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [OUT_W-1:0] y_out;
  logic out_valid, out_ready;
  logic [1:0] dbg_state;
  logic ready_man, bp_en, bp_bit;

  always #(CLK_P/2) clk = ~clk;

  assign out_ready = bp_en ? bp_bit : ready_man;

  always @(posedge clk) bp_bit <= 1'($urandom_range(0, 1));

  fir_filter_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int hist [TAPS];
  int cm   [TAPS];

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      cm[k]   = 0;
    end
    cm[0] = 1;
  endfunction

  function automatic int model_y();
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(cm[k]) * longint'(hist[k]);
    s = s >>> SHIFT;
    if (s > Y_MAX) s = Y_MAX;
    if (s < Y_MIN) s = Y_MIN;
    return int'(s);
  endfunction

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  longint t_q[$];
  int errors = 0;
  int checks = 0;
  logic prev_valid = 1'b0;
  logic [OUT_W-1:0] mon_e;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: latency on each rising out_valid, value on each output transfer.
  always @(negedge clk) begin
    if (reset && out_valid && !prev_valid && t_q.size() > 0)
      check("latency", longint'($time) - t_q[0], LAT);
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y_out=%0d, expected no output", $signed(y_out));
      end else begin
        mon_e = exp_q.pop_front();
        void'(t_q.pop_front());
        check("y_out", longint'($signed(y_out)), longint'($signed(mon_e)));
      end
    end
    prev_valid = out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    t_q.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    t_q.delete();
  endtask

  task automatic write_coef(input int addr, input int data, input bit apply);
    coef_we   = 1'b1;
    coef_addr = addr[ADDR_W-1:0];
    coef_data = data[COEF_W-1:0];
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (apply && addr < TAPS) cm[addr] = data;
  endtask

  // Issue one sample (optionally with a same-cycle coefficient write).
  task automatic send(input int x, input bit use_exp = 1'b0, input int expv = 0,
                      input bit wr = 1'b0, input int wa = 0, input int wd = 0);
    int e;
    x_in     = x[DATA_W-1:0];
    in_valid = 1'b1;
    coef_we   = wr;
    coef_addr = wa[ADDR_W-1:0];
    coef_data = wd[COEF_W-1:0];
    wait_idle();
    @(posedge clk);
    if (wr && wa < TAPS) cm[wa] = wd;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    e = use_exp ? expv : model_y();
    exp_q.push_back(e[OUT_W-1:0]);
    t_q.push_back(longint'($time));
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; in_valid = 1'b0; x_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    ready_man = 1'b1; bp_en = 1'b0;

    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", longint'($signed(y_out)), 0);
    check("rst_state", dbg_state, 0);

    // Pass-through coefficients after reset.
    send(10, 1, 10); send(20, 1, 20); send(30, 1, 30); send(40, 1, 40);
    drain();

    // Ramp coefficients.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, 1);
    send(10, 1, 10); send(20, 1, 40); send(30, 1, 100); send(40, 1, 200); send(0, 1, 250);
    drain();

    // Positive and negative saturation.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 127, 1);
    send(127, 1, 16129); send(127, 1, 32258); send(127, 1, 32767);
    drain();
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 127, 1);
    send(-128, 1, -16256); send(-128, 1, -32512); send(-128, 1, -32768);
    drain();

    // Coefficient write in the same cycle as a sample transfer.
    do_reset();
    send(7, 0, 0, 1, 1, 5);
    send(3, 1, 38);
    drain();

    // Output backpressure with in_valid pulses that must be ignored.
    ready_man = 1'b0;
    send(25);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("hold_reached_out", out_valid, 1);
    check("hold_state", dbg_state, 2);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in = DATA_W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      if (exp_q.size() > 0) check("hold_y_out", longint'($signed(y_out)), longint'($signed(exp_q[0])));
    end
    in_valid = 1'b0;
    ready_man = 1'b1;
    @(posedge clk);
    #1;
    check("hold_released", out_valid, 0);
    send(-9);
    drain();

    // Coefficient write during MAC is ignored.
    send(11);
    write_coef(0, 99, 0);
    send(12);
    drain();

    // Reset in the middle of MAC aborts the computation.
    send(13);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    t_q.delete();
    for (int i = 0; i < TAPS + 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_out_valid", out_valid, 0);
    end
    check("abort_y_out", longint'($signed(y_out)), 0);
    send(10, 1, 10);
    drain();

    // Randomized coefficients, samples and output backpressure.
    do_reset();
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128, 1);
      end
      send(int'($urandom_range(0, 255)) - 128);
    end
    drain();
    bp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
